// File: rtl/microp_pkg.sv
// Shared opcodes, FSM state encoding and instruction field positions for the
// multicycle microp core.
package microp_pkg;
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LI   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_OUT  = 4'd6;
  localparam logic [3:0] OP_BEQZ = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
endpackage

// File: rtl/microp_if.sv
// Program ROM fetch port plus display output of the microp core.
interface microp_if #(parameter int DATA_W = 8, parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] instr_addr;
  logic [15:0]       instr_data;
  logic [DATA_W-1:0] display;
  logic              display_valid;

  modport master (output instr_addr, display, display_valid, input instr_data);
  modport slave  (input instr_addr, display, display_valid, output instr_data);
endinterface

// File: rtl/microp_alu.sv
// Combinational ALU for ADD/SUB/AND/OR; carry is carry-out on ADD, borrow on SUB.
module microp_alu
  import microp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);
  logic [DATA_W:0] ext;

  // Top bit of the widened difference is set exactly when a < b.
  always_comb begin
    ext = '0;
    case (op)
      OP_ADD:  ext = {1'b0, a} + {1'b0, b};
      OP_SUB:  ext = {1'b0, a} - {1'b0, b};
      OP_AND:  ext = {1'b0, a & b};
      OP_OR:   ext = {1'b0, a | b};
      default: ext = '0;
    endcase
  end

  assign result = ext[DATA_W-1:0];
  assign carry  = ext[DATA_W];
  assign zero   = (result == '0);
endmodule

// File: rtl/microp_core.sv
// Two-cycle (FETCH/EXEC) register-file CPU with run/pause, branch, HALT,
// carry/zero flags and a sticky illegal-opcode flag.
module microp_core
  import microp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     run,
  microp_if.master bus,
  output logic     halted,
  output logic     zero,
  output logic     carry,
  output logic     illegal
);
  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       pc, pc_nxt;
  logic [15:0]             ir;
  logic [3:0][DATA_W-1:0]  rf;
  logic [3:0]              op;
  logic [1:0]              rd, rs;
  logic [7:0]              imm;
  logic [DATA_W-1:0]       imm_d, a, b, alu_res;
  logic                    alu_c, alu_z;

  assign op  = ir[OP_HI:OP_LO];
  assign rd  = ir[RD_HI:RD_LO];
  assign rs  = ir[RS_HI:RS_LO];
  assign imm = ir[IMM_HI:IMM_LO];
  assign a   = rf[rd];
  assign b   = rf[rs];

  generate
    if (DATA_W > 8) begin : g_imm_zext
      assign imm_d = {{(DATA_W-8){1'b0}}, imm};
    end else begin : g_imm_trunc
      assign imm_d = imm[DATA_W-1:0];
    end
  endgenerate

  microp_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  // pc_nxt is only consumed in EXEC; HALT keeps the PC pointing at itself.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc + ADDR_W'(1);
    case (state)
      ST_FETCH: if (run) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = (op == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_FETCH;
    endcase
    case (op)
      OP_BEQZ: if (b == '0) pc_nxt = imm[ADDR_W-1:0];
      OP_JMP:  pc_nxt = imm[ADDR_W-1:0];
      OP_HALT: pc_nxt = pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc                <= '0;
      ir                <= '0;
      rf                <= '0;
      bus.display       <= '0;
      bus.display_valid <= 1'b0;
      zero              <= 1'b0;
      carry             <= 1'b0;
      illegal           <= 1'b0;
    end else begin
      bus.display_valid <= 1'b0;
      if (state == ST_FETCH && run) ir <= bus.instr_data;
      if (state == ST_EXEC) begin
        pc <= pc_nxt;
        case (op)
          OP_LI: rf[rd] <= imm_d;
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            rf[rd] <= alu_res;
            zero   <= alu_z;
            carry  <= alu_c;
          end
          OP_OUT: begin
            bus.display       <= b;
            bus.display_valid <= 1'b1;
          end
          default: if (op > OP_HALT) illegal <= 1'b1;
        endcase
      end
    end
  end

  assign bus.instr_addr = pc;
  assign halted         = (state == ST_HALT);
endmodule
